// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, boot address and fetch-stage types.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small first-word-out queue holding fetched {pc, instr} entries in program order.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the count gates every use of the head entry.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, pipelined imem requests, in-order response queue.
module fetch_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC),
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_stage_if.master     imem,
    input  logic              stall_d,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [31:0]       instr_f,
    output logic [XLEN-1:0]   pc_f,
    output logic [XLEN-1:0]   pcplus4_f,
    output logic              valid_f,
    output logic              flush_d
);
    import riscv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENTRY_W = XLEN + 32;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] deliver_pc_reg, deliver_pc_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W:0]     occupancy;
    logic               resp, grant, push, pop, drop_now, req;

    // A response with nothing outstanding can only be left over from before a reset.
    assign resp     = imem.imem_rvalid && (outstanding_reg != '0);
    assign drop_now = resp && (drop_cnt_reg != '0);
    assign push     = resp && (drop_cnt_reg == '0) && !redirect;
    assign valid_f  = (fifo_count != '0);
    assign pop      = valid_f && !stall_d && !redirect;

    // A slot freed by this cycle's pop is reusable at once, giving back-to-back issue.
    assign occupancy = {1'b0, outstanding_reg} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
    assign req       = (state_reg != BOOT) && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign grant     = req && imem.imem_gnt;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_reg;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({deliver_pc_reg, imem.imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    always_comb begin
        outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(resp);
        fetch_pc_next    = fetch_pc_reg;
        deliver_pc_next  = deliver_pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        state_next       = state_reg;

        if (redirect) begin
            fetch_pc_next   = redirect_pc;
            deliver_pc_next = redirect_pc;
            // No grant this cycle, so this is every request still owed a response.
            drop_cnt_next   = outstanding_next;
            state_next      = (outstanding_next != '0) ? DRAIN : RUN;
        end else begin
            if (grant)    fetch_pc_next   = fetch_pc_reg + XLEN'(4);
            if (push)     deliver_pc_next = deliver_pc_reg + XLEN'(4);
            if (drop_now) drop_cnt_next   = drop_cnt_reg - CNT_W'(1);
            case (state_reg)
                BOOT:    state_next = RUN;
                RUN:     state_next = RUN;
                DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            deliver_pc_reg  <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            deliver_pc_reg  <= deliver_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    assign instr_f   = valid_f ? head_data[31:0] : 32'h0;
    assign pc_f      = valid_f ? head_data[ENTRY_W-1:32] : '0;
    assign pcplus4_f = pc_f + XLEN'(4);
    assign flush_d   = redirect || (!stall_d && !valid_f);
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven startup/stall vectors plus redirect/reset sequences.
module tb_fetch_stage;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] KEY = 32'h5A00_0000;

    logic            clk, reset, stall_d, redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     instr_f;
    logic [XLEN-1:0] pc_f, pcplus4_f;
    logic            valid_f, flush_d;

    fetch_stage_if #(.XLEN(XLEN)) imem_bus ();

    fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pcplus4_f   (pcplus4_f),
        .valid_f     (valid_f),
        .flush_d     (flush_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        gnt;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    vec_t        vec[13];
    int          cyc;
    int          lat;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One clock cycle: drive inputs and memory at negedge, settle, check, model the memory and scoreboard.
    task automatic cycle(input logic g, input logic s, input logic r, input logic [31:0] rpc);
        mreq_t       m;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        imem_bus.imem_gnt = g;
        stall_d = s;
        redirect = r;
        redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = mq[0].addr ^ KEY;
            void'(mq.pop_front());
        end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = 32'h0;
        end
        #1;
        check("flush_d", 32'(flush_d), 32'(r | (!s & !valid_f)));
        if (imem_bus.imem_req && g) begin
            m.addr = imem_bus.imem_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
        if (r) begin
            sb_load(rpc);
        end else if (valid_f && !s) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got pc %h expected no delivery", pc_f);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc_f, e);
                check("sb_instr", instr_f, e ^ KEY);
                check("sb_pcplus4", pcplus4_f, e + 32'd4);
            end
        end
        $display("cyc %0d: req=%b addr=%h rvalid=%b valid_f=%b pc_f=%h instr_f=%h flush_d=%b",
                 cyc, imem_bus.imem_req, imem_bus.imem_addr, imem_bus.imem_rvalid,
                 valid_f, pc_f, instr_f, flush_d);
    endtask

    // Asserts reset mid-cycle (memory resets too) and checks outputs go to reset values immediately.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall_d = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        mq.delete();
        sb_load(32'h0);
        cyc = 0;
        #1;
        check("rst_req", 32'(imem_bus.imem_req), 32'h0);
        check("rst_addr", imem_bus.imem_addr, 32'h0);
        check("rst_valid", 32'(valid_f), 32'h0);
        check("rst_instr", instr_f, 32'h0);
        check("rst_pc", pc_f, 32'h0);
        check("rst_pcplus4", pcplus4_f, 32'h4);
        check("rst_flush", 32'(flush_d), 32'h1);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(valid_f), 32'h0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!valid_f && k < budget) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            k++;
        end
        check(name, 32'(valid_f), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // gnt, stall, exp_req, exp_addr, exp_valid, exp_pc
        vec[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vec[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vec[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vec[3]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vec[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vec[10] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vec[11] = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        vec[12] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};

        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        lat = 1;
        reset = 1'b1;
        stall_d = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        // Startup latency, back-to-back delivery, then a 5-cycle stall holding pc 0x8.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(vec[i].gnt, vec[i].stall, 1'b0, 32'h0);
            check($sformatf("vec%0d_req", i), 32'(imem_bus.imem_req), 32'(vec[i].exp_req));
            check($sformatf("vec%0d_addr", i), imem_bus.imem_addr, vec[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(valid_f), 32'(vec[i].exp_valid));
            if (vec[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), pc_f, vec[i].exp_pc);
                check($sformatf("vec%0d_instr", i), instr_f, vec[i].exp_pc ^ KEY);
            end
        end

        // Grant withheld for 4 cycles: request held steady at 0x1C, queue runs dry.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            check("nognt_req", 32'(imem_bus.imem_req), 32'h1);
            check("nognt_addr", imem_bus.imem_addr, 32'h1C);
        end
        check("nognt_valid_low", 32'(valid_f), 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x100 with two requests outstanding (3-cycle memory).
        lat = 3;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h100);
        check("redir_req", 32'(imem_bus.imem_req), 32'h0);
        wait_valid("redir_valid_seen", 20);
        check("redir_first_pc", pc_f, 32'h100);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect coincident with a response and a stall: that response and the next are stale.
        lat = 2;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        check("rvs_rvalid_seen", 32'(imem_bus.imem_rvalid), 32'h1);
        check("rvs_req", 32'(imem_bus.imem_req), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rvs_valid_after", 32'(valid_f), 32'h0);
        wait_valid("rvs_valid_seen", 20);
        check("rvs_first_pc", pc_f, 32'h200);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset while draining one stale response, then restart and sustained throughput.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h300);
        do_reset();
        lat = 1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("restart_boot_req", 32'(imem_bus.imem_req), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("restart_req", 32'(imem_bus.imem_req), 32'h1);
        check("restart_addr", imem_bus.imem_addr, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check("tput_valid", 32'(valid_f), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined RISC-V core. Generates fetch PCs and issues requests to instruction memory with up to DEPTH requests in flight, buffering responses in a small in-order queue. Presents {instr_f, pc_f, pcplus4_f} to the IF/ID pipeline register and drives that register's synchronous clear (flush_d) for branch redirects and fetch bubbles. Honours stall_d from the hazard unit and redirect from the execute stage.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, max outstanding requests plus buffered instructions (≥1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (word aligned)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- stall_d  in  1  hold IF/ID register; do not consume instruction
- redirect  in  1  branch/jump taken; restart at redirect_pc
- redirect_pc  in  XLEN  redirect target
- instr_f  out  32  instruction at queue head
- pc_f  out  XLEN  PC of instr_f
- pcplus4_f  out  XLEN  pc_f + 4
- valid_f  out  1  queue head holds an instruction
- flush_d  out  1  synchronous clear for IF/ID register

## Operation
- Registers: fetch_pc (next request address), deliver_pc (PC of next accepted response), outstanding count, drop_cnt, queue of {pc, instr}, state.
- FSM: BOOT → RUN unconditionally one cycle after reset release; RUN → DRAIN on redirect with drop count > 0; DRAIN → RUN when drop_cnt reaches 0 with no pending redirect; redirect in any state re-evaluates.
- Issue: imem_req = (state != BOOT) & !redirect & (outstanding + queue_count < DEPTH); imem_addr = fetch_pc. On req & gnt: fetch_pc += 4, outstanding++.
- Response: on imem_rvalid outstanding--. If drop_cnt > 0: drop_cnt--, data discarded. Otherwise push {deliver_pc, imem_rdata}, deliver_pc += 4. Issue rule guarantees no overflow.
- Consume: pop head when valid_f & !stall_d & !redirect.
- flush_d = redirect | (!stall_d & !valid_f) — combinational; IF/ID loads a bubble when nothing is available.
- Redirect (priority over everything): fetch_pc ← redirect_pc, deliver_pc ← redirect_pc, queue emptied, drop_cnt ← outstanding − imem_rvalid (response in the redirect cycle is discarded), no request issued that cycle.
- PC arithmetic modulo 2^XLEN; wrap at all-ones is silent.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, valid_f 0, instr_f 0, pc_f 0, pcplus4_f 4, flush_d 1 (stall_d low), outstanding 0, drop_cnt 0, state BOOT.
- Reset asserted mid-operation: all state cleared immediately; in-flight responses after release must not be pushed (memory is reset together with the core).
- Latency: grant in cycle N, response N+1, valid_f in N+2. Redirect in cycle R: first new request R+1, earliest valid_f R+3 (fixed-latency-1 memory, no stale drops).
- Sustained throughput 1 instr/cycle with DEPTH ≥ 2 and single-cycle memory.
- stall_d held: queue fills to DEPTH − outstanding, then imem_req drops; head stable.
- redirect with stall_d: redirect wins; flush_d = 1, queue emptied.
- Response and pop in same cycle: both take effect; count unchanged.

## Structure
- Shared riscv_pkg: XLEN, RESET_PC default, fetch_state_t enum {BOOT, RUN, DRAIN}, fetch_entry_t struct {pc, instr}.
- One sub-module: fetch_fifo (synchronous, DEPTH-entry, push/pop/clear, count, first-word-out); counters and FSM stay in fetch_stage.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning addr as data -> first req addr 0x0 cycle 1, valid_f cycle 3 with pc_f 0x0, then pc 0x4, 0x8 every cycle; flush_d 1 until first valid.
- stall_d high 5 cycles at pc_f 0x8 -> pc_f/instr_f hold 0x8, imem_req drops after queue full, resume yields 0xC with no skip or repeat.
- Redirect to 0x100 with 2 requests outstanding -> both stale responses dropped, next pc_f 0x100, flush_d 1 in redirect cycle.
- Redirect coincident with imem_rvalid and stall_d -> response discarded, drop_cnt = outstanding − 1, redirect target delivered next.
- gnt held low 4 cycles -> imem_req/imem_addr stable, valid_f falls, flush_d 1 each unstalled empty cycle.
- Reset asserted while DRAIN with drop_cnt 1 -> all outputs at reset values same cycle; restart at RESET_PC.
